// File: rtl/fechadura_pkg.sv
// fechadura_pkg -- shared types for the lock's password datapath.
//   senhaPac_t : keypad packet, 20 BCD digits, digits[0] = newest key
//   senha_t    : stored password, [0] = first digit, 0xF padded
//   estado_t   : validator FSM states
//   senha_len / senha_confere : slot length and suffix-match helpers
package fechadura_pkg;

    localparam int PAC_DIG   = 20;
    localparam int SENHA_DIG = 19;

    localparam logic [3:0] DIG_STAR  = 4'hA;
    localparam logic [3:0] DIG_HASH  = 4'hB;
    localparam logic [3:0] DIG_TMO   = 4'hE;
    localparam logic [3:0] DIG_VAZIO = 4'hF;

    typedef struct packed {
        logic [PAC_DIG-1:0][3:0] digits;
    } senhaPac_t;

    typedef logic [SENHA_DIG-1:0][3:0] senha_t;

    typedef enum logic [1:0] {
        IDLE,
        COMPARA,
        RESULT,
        BLOQUEIO
    } estado_t;

    // Number of leading non-empty digits; a gap ends the password.
    function automatic logic [4:0] senha_len(senha_t s);
        logic [4:0] n;
        logic       run;
        n   = '0;
        run = 1'b1;
        for (int i = 0; i < SENHA_DIG; i++) begin
            if (run && s[i] != DIG_VAZIO) n = n + 5'd1;
            else                          run = 1'b0;
        end
        return n;
    endfunction

    // The last L keys before '#' (digits[L..1]) must spell the slot in
    // order; older keys are don't-care. Out-of-range lengths never match.
    function automatic logic senha_confere(senhaPac_t p, senha_t s,
                                           int min_dig, int max_dig);
        logic [4:0] len;
        logic [4:0] pos;
        logic       ok;
        len = senha_len(s);
        ok  = (int'(len) >= min_dig) && (int'(len) <= max_dig);
        for (int k = 0; k < SENHA_DIG; k++) begin
            pos = len - 5'(k);
            if (k < int'(len) && p.digits[pos] != s[k]) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/temporizador_ms.sv
// temporizador_ms -- loadable millisecond down-counter.
//   clk, rst  : clock, synchronous active-high reset
//   load      : load valor_ms (loading 0 stops the timer at once)
//   valor_ms  : duration in milliseconds
//   ativo     : high while the count is non-zero
// With CLK_HZ = 1000 every cycle is one tick, so ativo stays high for
// exactly valor_ms cycles after the load edge.
module temporizador_ms #(
    parameter int CLK_HZ = 1000,
    parameter int W      = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] valor_ms,
    output logic         ativo
);

    localparam int PRE = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
    localparam int PW  = (PRE > 1) ? $clog2(PRE) : 1;

    logic [W-1:0]  cnt;
    logic [PW-1:0] pre;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            pre <= '0;
        end else if (load) begin
            cnt <= valor_ms;
            pre <= '0;
        end else if (cnt != '0) begin
            if (pre == PW'(PRE - 1)) begin
                pre <= '0;
                cnt <= cnt - W'(1);
            end else begin
                pre <= pre + PW'(1);
            end
        end
    end

    assign ativo = (cnt != '0);

endmodule

// File: rtl/validador_senhas_param.sv
// validador_senhas_param -- keypad password validator with escalating lockout.
//   clk, rst       : clock, synchronous active-high reset
//   digitos_value  : keypad packet (0xF empty, 0xA '*', 0xB '#', all-0xE timeout)
//   digitos_valid  : packet strobe
//   cfg_senhas     : stored passwords, loaded on cfg_valid
//   cfg_mestre     : master password (only with MASTER_SENHA_EN)
//   busy           : comparison running
//   abrir / falha  : one-cycle result pulses; idx_match valid with abrir
//   tentativas     : consecutive failures
//   bloqueado      : lockout running
//   bip            : buzzer pulse
// Build option: define MASTER_SENHA_EN to add the master code, checked one
// cycle after the last slot and honoured even during lockout.
module validador_senhas_param
    import fechadura_pkg::*;
#(
    parameter int CLK_HZ       = 1000,
    parameter int NUM_SENHAS   = 4,
    parameter int MIN_DIG      = 4,
    parameter int MAX_DIG      = 12,
    parameter int MAX_TENT     = 3,
    parameter int BLOQ_S       = 30,
    parameter int BLOQ_MAX_EXP = 3,
    parameter int BIP_MS       = 200,
    localparam int IDX_W  = (NUM_SENHAS > 1) ? $clog2(NUM_SENHAS) : 1,
    localparam int TENT_W = $clog2(MAX_TENT + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  senhaPac_t                     digitos_value,
    input  logic                          digitos_valid,
    input  senha_t [NUM_SENHAS-1:0]       cfg_senhas,
`ifdef MASTER_SENHA_EN
    input  senha_t                        cfg_mestre,
`endif
    input  logic                          cfg_valid,
    output logic                          busy,
    output logic                          abrir,
    output logic                          falha,
    output logic [IDX_W-1:0]              idx_match,
    output logic [TENT_W-1:0]             tentativas,
    output logic                          bloqueado,
    output logic                          bip
);

    localparam int EXP_W = (BLOQ_MAX_EXP > 0) ? $clog2(BLOQ_MAX_EXP + 1) : 1;
    localparam int K_W   = $clog2(NUM_SENHAS + 1);
    localparam int TW    = 32;
`ifdef MASTER_SENHA_EN
    localparam int LAST_K = NUM_SENHAS;      // extra cycle for the master code
`else
    localparam int LAST_K = NUM_SENHAS - 1;
`endif

    estado_t                   estado, estado_n;
    senha_t [NUM_SENHAS-1:0]   slots;
    senhaPac_t                 pac_q;
    logic [K_W-1:0]            k;
    logic                      hit;
    logic [IDX_W-1:0]          hit_idx;
    logic [TENT_W-1:0]         tent;
    logic [EXP_W-1:0]          expo;
    logic                      em_bloq;      // compare launched from lockout
    senha_t                    slot_sel;
    logic                      slot_hit;
    logic                      mestre_hit;
    logic                      pac_ok, pac_tmo, pac_hash;
    logic                      bip_load, lock_load;
    logic [TW-1:0]             lock_val;
`ifdef MASTER_SENHA_EN
    senha_t                    mestre_q;
`endif

    // cfg_valid wins over a packet in the same cycle
    assign pac_ok   = digitos_valid && !cfg_valid;
    assign pac_tmo  = (digitos_value.digits == {PAC_DIG{DIG_TMO}});
    assign pac_hash = (digitos_value.digits[0] == DIG_HASH);

    // One comparator shared across slots; k past the last slot selects an
    // all-empty password, which can never match.
    always_comb begin
        slot_sel = '1;
        for (int i = 0; i < NUM_SENHAS; i++)
            if (k == K_W'(i)) slot_sel = slots[i];
    end

    assign slot_hit = !em_bloq && senha_confere(pac_q, slot_sel, MIN_DIG, MAX_DIG);
`ifdef MASTER_SENHA_EN
    assign mestre_hit = (k == K_W'(NUM_SENHAS))
                     && senha_confere(pac_q, mestre_q, MIN_DIG, MAX_DIG);
`else
    assign mestre_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) estado <= IDLE;
        else     estado <= estado_n;
    end

    always_comb begin
        estado_n  = estado;
        bip_load  = 1'b0;
        lock_load = 1'b0;
        lock_val  = '0;
        case (estado)
            IDLE: begin
                if (pac_ok) begin
                    if (pac_tmo)       bip_load = 1'b1;
                    else if (pac_hash) estado_n = COMPARA;
                end
            end
            COMPARA: begin
                if (cfg_valid)                estado_n = em_bloq ? BLOQUEIO : IDLE;
                else if (k == K_W'(LAST_K))   estado_n = RESULT;
            end
            RESULT: begin
                if (hit) begin
                    estado_n = IDLE;
                    if (em_bloq) lock_load = 1'b1;   // master code ends lockout
                end else if (em_bloq) begin
                    estado_n = BLOQUEIO;
                end else begin
                    bip_load = 1'b1;
                    if (tent == TENT_W'(MAX_TENT - 1)) begin
                        estado_n  = BLOQUEIO;
                        lock_load = 1'b1;
                        lock_val  = TW'(BLOQ_S * 1000) << expo;
                    end else begin
                        estado_n = IDLE;
                    end
                end
            end
            BLOQUEIO: begin
                if (!bloqueado) begin
                    estado_n = IDLE;
                end else if (pac_ok) begin
                    bip_load = 1'b1;
`ifdef MASTER_SENHA_EN
                    if (pac_hash) estado_n = COMPARA;
`endif
                end
            end
            default: estado_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slots   <= '1;
            pac_q   <= '1;
            k       <= '0;
            hit     <= 1'b0;
            hit_idx <= '0;
            tent    <= '0;
            expo    <= '0;
            em_bloq <= 1'b0;
`ifdef MASTER_SENHA_EN
            mestre_q <= '1;
`endif
        end else begin
            if (cfg_valid) begin
                slots <= cfg_senhas;
`ifdef MASTER_SENHA_EN
                mestre_q <= cfg_mestre;
`endif
            end
            case (estado)
                IDLE: begin
                    if (estado_n == COMPARA) begin
                        pac_q   <= digitos_value;
                        k       <= '0;
                        hit     <= 1'b0;
                        hit_idx <= '0;
                        em_bloq <= 1'b0;
                    end
                end
                COMPARA: begin
                    k <= k + K_W'(1);
                    // first hit sticks, so the lowest slot wins
                    if (!hit && slot_hit) begin
                        hit     <= 1'b1;
                        hit_idx <= k[IDX_W-1:0];
                    end else if (!hit && mestre_hit) begin
                        hit     <= 1'b1;
                        hit_idx <= '1;
                    end
                end
                RESULT: begin
                    if (hit) begin
                        tent <= '0;
                        expo <= '0;
                    end else if (!em_bloq) begin
                        tent <= tent + TENT_W'(1);
                        if (estado_n == BLOQUEIO && expo != EXP_W'(BLOQ_MAX_EXP))
                            expo <= expo + EXP_W'(1);
                    end
                end
                BLOQUEIO: begin
                    if (!bloqueado) begin
                        tent <= '0;
`ifdef MASTER_SENHA_EN
                    end else if (estado_n == COMPARA) begin
                        pac_q   <= digitos_value;
                        k       <= '0;
                        hit     <= 1'b0;
                        hit_idx <= '0;
                        em_bloq <= 1'b1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = (estado == COMPARA);
    assign abrir      = (estado == RESULT) && hit;
    assign falha      = (estado == RESULT) && !hit && !em_bloq;
    assign idx_match  = abrir ? hit_idx : '0;
    assign tentativas = tent;

    temporizador_ms #(.CLK_HZ(CLK_HZ), .W(TW)) u_bip (
        .clk      (clk),
        .rst      (rst),
        .load     (bip_load),
        .valor_ms (TW'(BIP_MS)),
        .ativo    (bip)
    );

    temporizador_ms #(.CLK_HZ(CLK_HZ), .W(TW)) u_bloq (
        .clk      (clk),
        .rst      (rst),
        .load     (lock_load),
        .valor_ms (lock_val),
        .ativo    (bloqueado)
    );

endmodule
